// File: rtl/vga_pkg.sv
// Shared video-subsystem constants: pixel-state encodings and VRAM layout.
package vga_pkg;

    typedef enum logic [1:0] {
        TEXT_FETCH  = 2'd0,
        GLYPH_FETCH = 2'd1,
        WAIT        = 2'd2,
        DRAW        = 2'd3
    } pixel_state_e;

    localparam int unsigned SIZE_TEXT  = 8192;
    localparam int unsigned SIZE_GLYPH = 1024;
    localparam int unsigned ADDR_TEXT  = 0;
    localparam int unsigned ADDR_GLYPH = 8192;
    localparam int unsigned MEM_WORDS  = SIZE_TEXT + SIZE_GLYPH;

endpackage

// File: rtl/vram_req_fifo.sv
// Synchronous FIFO of CPU VRAM requests {we, addr, wdata}; head is visible combinationally.
module vram_req_fifo #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned FIFO_AW    = 2,
    parameter int unsigned ADDR_WIDTH = 15,
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_push,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_pop,
    output logic                  o_we,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [DATA_WIDTH-1:0] o_wdata,
    output logic                  o_empty,
    output logic                  o_full
);

    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } entry_t;

    entry_t             r_mem [FIFO_DEPTH];
    logic [FIFO_AW:0]   r_wr_ptr;
    logic [FIFO_AW:0]   r_rd_ptr;
    logic [FIFO_AW-1:0] w_wr_idx;
    logic [FIFO_AW-1:0] w_rd_idx;

    assign w_wr_idx = r_wr_ptr[FIFO_AW-1:0];
    assign w_rd_idx = r_rd_ptr[FIFO_AW-1:0];

    // Extra pointer MSB distinguishes full from empty when the low bits match.
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (w_wr_idx == w_rd_idx) && (r_wr_ptr[FIFO_AW] != r_rd_ptr[FIFO_AW]);

    assign o_we    = r_mem[w_rd_idx].we;
    assign o_addr  = r_mem[w_rd_idx].addr;
    assign o_wdata = r_mem[w_rd_idx].wdata;

    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[w_wr_idx] <= '{we: i_we, addr: i_addr, wdata: i_wdata};
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + (FIFO_AW + 1)'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + (FIFO_AW + 1)'(1);
            end
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: video fetches own pixel states 0/1, queued CPU requests use the rest.
module vram_arbiter #(
    parameter int unsigned ADDR_WIDTH = 15,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned MEM_WORDS  = vga_pkg::MEM_WORDS,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned FIFO_AW    = 2
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_video_enable,
    input  logic [1:0]            i_pixel_state,
    input  logic [ADDR_WIDTH-1:0] i_pg_addr,
    output logic [DATA_WIDTH-1:0] o_pg_data,
    input  logic                  i_cpu_req_valid,
    output logic                  o_cpu_req_ready,
    input  logic                  i_cpu_req_we,
    input  logic [ADDR_WIDTH-1:0] i_cpu_req_addr,
    input  logic [DATA_WIDTH-1:0] i_cpu_req_wdata,
    output logic                  o_cpu_rsp_valid,
    output logic [DATA_WIDTH-1:0] o_cpu_rsp_data,
    output logic                  o_err_oob,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic                  o_mem_we,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

    import vga_pkg::*;

    pixel_state_e          w_state;
    logic                  w_video_slot;
    logic                  w_fifo_empty;
    logic                  w_fifo_full;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_head_we;
    logic [ADDR_WIDTH-1:0] w_head_addr;
    logic [DATA_WIDTH-1:0] w_head_wdata;
    logic                  w_head_oob;
    logic [ADDR_WIDTH-1:0] w_mem_addr;
    logic                  w_mem_we;
    logic [DATA_WIDTH-1:0] w_mem_wdata;
    logic [DATA_WIDTH-1:0] w_pg_data;
    logic                  w_rsp_valid;
    logic [DATA_WIDTH-1:0] w_rsp_data;

    logic                  r_video_rd;
    logic                  r_rsp_pend;
    logic                  r_rsp_oob;
    logic                  r_err_oob;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic [DATA_WIDTH-1:0] r_pg_data;
    logic [DATA_WIDTH-1:0] r_rsp_data;

    assign w_state      = pixel_state_e'(i_pixel_state);
    assign w_video_slot = i_video_enable && ((w_state == TEXT_FETCH) || (w_state == GLYPH_FETCH));

    // Reset gates the handshake and issue combinationally so nothing slips through a reset cycle.
    assign o_cpu_req_ready = i_reset && !w_fifo_full;
    assign w_push          = i_cpu_req_valid && o_cpu_req_ready;
    assign w_pop           = i_reset && !w_video_slot && !w_fifo_empty;
    assign w_head_oob      = 32'(w_head_addr) >= MEM_WORDS;

    vram_req_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .FIFO_AW    (FIFO_AW),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (w_push),
        .i_we    (i_cpu_req_we),
        .i_addr  (i_cpu_req_addr),
        .i_wdata (i_cpu_req_wdata),
        .i_pop   (w_pop),
        .o_we    (w_head_we),
        .o_addr  (w_head_addr),
        .o_wdata (w_head_wdata),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full)
    );

    always_comb begin
        w_mem_addr  = r_mem_addr;
        w_mem_we    = 1'b0;
        w_mem_wdata = r_mem_wdata;
        if (!i_reset) begin
            w_mem_addr  = '0;
            w_mem_wdata = '0;
        end else if (w_video_slot) begin
            w_mem_addr = i_pg_addr;
        end else if (w_pop) begin
            w_mem_addr  = w_head_addr;
            w_mem_we    = w_head_we && !w_head_oob;
            w_mem_wdata = w_head_wdata;
        end
    end

    // RAM data arrives one clock after the address, so both consumers pick it up live.
    assign w_pg_data   = (i_reset && r_video_rd) ? i_mem_rdata : r_pg_data;
    assign w_rsp_valid = i_reset && r_rsp_pend;
    assign w_rsp_data  = w_rsp_valid ? (r_rsp_oob ? '0 : i_mem_rdata) : r_rsp_data;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_video_rd  <= 1'b0;
            r_rsp_pend  <= 1'b0;
            r_rsp_oob   <= 1'b0;
            r_err_oob   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_pg_data   <= '0;
            r_rsp_data  <= '0;
        end else begin
            r_video_rd  <= w_video_slot;
            r_rsp_pend  <= w_pop && !w_head_we;
            r_rsp_oob   <= w_head_oob;
            r_mem_addr  <= w_mem_addr;
            r_mem_wdata <= w_mem_wdata;
            r_pg_data   <= w_pg_data;
            r_rsp_data  <= w_rsp_data;
            if (w_pop && w_head_oob) begin
                r_err_oob <= 1'b1;
            end
        end
    end

    assign o_pg_data       = w_pg_data;
    assign o_cpu_rsp_valid = w_rsp_valid;
    assign o_cpu_rsp_data  = w_rsp_data;
    assign o_err_oob       = r_err_oob;
    assign o_mem_addr      = w_mem_addr;
    assign o_mem_we        = w_mem_we;
    assign o_mem_wdata     = w_mem_wdata;

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter with a behavioural synchronous VRAM and request scoreboard.
module tb_vram_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        video_enable = 1'b0;
    logic [1:0]  pixel_state = 2'd0;
    logic [14:0] pg_addr = '0;
    logic [15:0] pg_data;
    logic        cpu_req_valid = 1'b0;
    logic        cpu_req_ready;
    logic        cpu_req_we = 1'b0;
    logic [14:0] cpu_req_addr = '0;
    logic [15:0] cpu_req_wdata = '0;
    logic        cpu_rsp_valid;
    logic [15:0] cpu_rsp_data;
    logic        err_oob;
    logic [14:0] mem_addr;
    logic        mem_we;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = '0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] vram   [0:32767];
    logic [15:0] shadow [0:9215];
    logic [30:0] exp_wr_q  [$];
    logic [15:0] exp_rsp_q [$];
    logic [30:0] mon_w;
    logic [15:0] mon_r;

    vram_arbiter u_dut (
        .i_clk           (clk),
        .i_reset         (reset),
        .i_video_enable  (video_enable),
        .i_pixel_state   (pixel_state),
        .i_pg_addr       (pg_addr),
        .o_pg_data       (pg_data),
        .i_cpu_req_valid (cpu_req_valid),
        .o_cpu_req_ready (cpu_req_ready),
        .i_cpu_req_we    (cpu_req_we),
        .i_cpu_req_addr  (cpu_req_addr),
        .i_cpu_req_wdata (cpu_req_wdata),
        .o_cpu_rsp_valid (cpu_rsp_valid),
        .o_cpu_rsp_data  (cpu_rsp_data),
        .o_err_oob       (err_oob),
        .o_mem_addr      (mem_addr),
        .o_mem_we        (mem_we),
        .o_mem_wdata     (mem_wdata),
        .i_mem_rdata     (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) pixel_state <= pixel_state + 2'd1;

    always @(posedge clk) begin
        if (mem_we) vram[mem_addr] <= mem_wdata;
        mem_rdata <= vram[mem_addr];
    end

    // Memory-side and response-side scoreboard.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            n_checks++;
            if (exp_wr_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got addr=%h data=%h, required no write",
                         mem_addr, mem_wdata);
            end else begin
                mon_w = exp_wr_q.pop_front();
                if ({mem_addr, mem_wdata} !== mon_w) begin
                    n_fail++;
                    $display("FAIL write_order: got addr=%h data=%h, required addr=%h data=%h",
                             mem_addr, mem_wdata, mon_w[30:16], mon_w[15:0]);
                end
            end
            n_checks++;
            if (video_enable && !pixel_state[1]) begin
                n_fail++;
                $display("FAIL write_in_video_slot: got mem_we=1 in state %0d, required 0",
                         pixel_state);
            end
        end
        if (cpu_rsp_valid === 1'b1) begin
            n_checks++;
            if (exp_rsp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_rsp: got data=%h, required no pulse", cpu_rsp_data);
            end else begin
                mon_r = exp_rsp_q.pop_front();
                if (cpu_rsp_data !== mon_r) begin
                    n_fail++;
                    $display("FAIL rsp_data: got %h, required %h", cpu_rsp_data, mon_r);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic goto_state(input logic [1:0] s);
        for (int i = 0; i < 8; i++) begin
            tick();
            if (pixel_state == s) break;
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 64; i++) begin
            if (exp_wr_q.size() == 0 && exp_rsp_q.size() == 0) break;
            tick();
        end
        tick();
        tick();
    endtask

    task automatic send(input logic we, input logic [14:0] addr, input logic [15:0] data);
        logic accepted = 1'b0;
        cpu_req_valid = 1'b1;
        cpu_req_we    = we;
        cpu_req_addr  = addr;
        cpu_req_wdata = data;
        for (int i = 0; i < 32 && !accepted; i++) begin
            @(negedge clk);
            accepted = (cpu_req_ready === 1'b1);
            tick();
        end
        cpu_req_valid = 1'b0;
        n_checks++;
        if (!accepted) begin
            n_fail++;
            $display("FAIL send_accept: got ready=0 for 32 cycles, required acceptance");
        end else if (we) begin
            if (addr < 15'd9216) begin
                shadow[addr] = data;
                exp_wr_q.push_back({addr, data});
            end
        end else begin
            exp_rsp_q.push_back((addr < 15'd9216) ? shadow[addr] : 16'h0000);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        n_checks++;
        if ({pg_data, cpu_rsp_valid, cpu_rsp_data, err_oob} !== 34'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got pg=%h rv=%b rd=%h err=%b, required all 0",
                     pg_data, cpu_rsp_valid, cpu_rsp_data, err_oob);
        end
        n_checks++;
        if ({mem_addr, mem_we, mem_wdata} !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_mem: got addr=%h we=%b wdata=%h, required 0",
                     mem_addr, mem_we, mem_wdata);
        end
        n_checks++;
        if (cpu_req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready_low: got %b, required 0", cpu_req_ready);
        end
        tick();
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (cpu_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready_high: got %b, required 1", cpu_req_ready);
        end
        n_checks++;
        if (mem_addr !== 15'h0 || mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_mem: got addr=%h we=%b, required 0/0", mem_addr, mem_we);
        end
    endtask

    task automatic test_video_fetch();
        video_enable = 1'b1;
        goto_state(2'd0);
        pg_addr = 15'h0005;
        @(negedge clk);
        n_checks++;
        if (mem_addr !== 15'h0005 || mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL video_addr0: got addr=%h we=%b, required 0005/0", mem_addr, mem_we);
        end
        tick();
        pg_addr = 15'h2104;
        @(negedge clk);
        n_checks++;
        if (pg_data !== 16'h0041) begin
            n_fail++;
            $display("FAIL video_char: got %h, required 0041", pg_data);
        end
        n_checks++;
        if (mem_addr !== 15'h2104) begin
            n_fail++;
            $display("FAIL video_addr1: got %h, required 2104", mem_addr);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (pg_data !== 16'h3C66) begin
            n_fail++;
            $display("FAIL video_glyph: got %h, required 3c66", pg_data);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (pg_data !== 16'h3C66) begin
            n_fail++;
            $display("FAIL video_hold: got %h, required 3c66", pg_data);
        end
    endtask

    task automatic test_write_slotting();
        video_enable = 1'b1;
        goto_state(2'd0);
        cpu_req_valid = 1'b1;
        cpu_req_we    = 1'b1;
        cpu_req_addr  = 15'h0010;
        cpu_req_wdata = 16'hBEEF;
        @(negedge clk);
        n_checks++;
        if (cpu_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL slot_accept: got ready=%b, required 1", cpu_req_ready);
        end
        shadow[15'h0010] = 16'hBEEF;
        exp_wr_q.push_back({15'h0010, 16'hBEEF});
        tick();
        cpu_req_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL slot_state1: got mem_we=%b, required 0", mem_we);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (mem_we !== 1'b1 || mem_addr !== 15'h0010 || mem_wdata !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL slot_state2: got we=%b addr=%h data=%h, required 1/0010/beef",
                     mem_we, mem_addr, mem_wdata);
        end
        wait_drain();
    endtask

    task automatic test_backpressure();
        int   sent     = 0;
        int   cnt      = 0;
        logic exp_rdy;
        logic saw_low  = 1'b0;
        video_enable = 1'b1;
        goto_state(2'd0);
        for (int cyc = 0; cyc < 40 && sent < 8; cyc++) begin
            cpu_req_valid = 1'b1;
            cpu_req_we    = 1'b1;
            cpu_req_addr  = 15'h0020 + 15'(sent);
            cpu_req_wdata = 16'hA000 + 16'(sent);
            @(negedge clk);
            exp_rdy = (cnt < 4);
            n_checks++;
            if (cpu_req_ready !== exp_rdy) begin
                n_fail++;
                $display("FAIL bp_ready: cycle %0d got %b, required %b", cyc, cpu_req_ready,
                         exp_rdy);
            end
            if (!exp_rdy) saw_low = 1'b1;
            if ((!video_enable || pixel_state[1]) && cnt > 0) cnt--;
            if (exp_rdy) begin
                shadow[cpu_req_addr] = cpu_req_wdata;
                exp_wr_q.push_back({cpu_req_addr, cpu_req_wdata});
                sent++;
                cnt++;
            end
            tick();
        end
        cpu_req_valid = 1'b0;
        n_checks++;
        if (sent != 8 || !saw_low) begin
            n_fail++;
            $display("FAIL bp_progress: got sent=%0d backpressure=%b, required 8/1", sent, saw_low);
        end
        wait_drain();
        n_checks++;
        if (exp_wr_q.size() != 0) begin
            n_fail++;
            $display("FAIL bp_drain: got %0d writes pending, required 0", exp_wr_q.size());
        end
    endtask

    task automatic test_read();
        int          issue_cyc = -1;
        int          rsp_cyc   = -1;
        int          pulses    = 0;
        logic [15:0] rsp_val   = '0;
        video_enable = 1'b0;
        send(1'b1, 15'h0100, 16'h1234);
        send(1'b0, 15'h0100, 16'h0000);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (issue_cyc < 0 && mem_addr === 15'h0100 && mem_we === 1'b0) issue_cyc = c;
            if (cpu_rsp_valid === 1'b1) begin
                pulses++;
                rsp_cyc = c;
                rsp_val = cpu_rsp_data;
            end
            tick();
        end
        n_checks++;
        if (pulses != 1) begin
            n_fail++;
            $display("FAIL read_pulses: got %0d, required 1", pulses);
        end
        n_checks++;
        if (issue_cyc < 0 || rsp_cyc != issue_cyc + 1) begin
            n_fail++;
            $display("FAIL read_latency: got issue=%0d rsp=%0d, required rsp=issue+1",
                     issue_cyc, rsp_cyc);
        end
        n_checks++;
        if (rsp_val !== 16'h1234 || cpu_rsp_data !== 16'h1234) begin
            n_fail++;
            $display("FAIL read_data_hold: got pulse=%h now=%h, required 1234", rsp_val,
                     cpu_rsp_data);
        end
    endtask

    task automatic test_out_of_range();
        video_enable = 1'b0;
        n_checks++;
        if (err_oob !== 1'b0) begin
            n_fail++;
            $display("FAIL oob_initial: got err_oob=%b, required 0", err_oob);
        end
        send(1'b1, 15'h2400, 16'hFFFF);
        send(1'b0, 15'h2400, 16'h0000);
        wait_drain();
        n_checks++;
        if (exp_rsp_q.size() != 0) begin
            n_fail++;
            $display("FAIL oob_rsp_missing: got %0d pending, required 0", exp_rsp_q.size());
        end
        n_checks++;
        if (err_oob !== 1'b1) begin
            n_fail++;
            $display("FAIL oob_flag: got %b, required 1", err_oob);
        end
        send(1'b1, 15'h0101, 16'h5555);
        wait_drain();
        n_checks++;
        if (err_oob !== 1'b1) begin
            n_fail++;
            $display("FAIL oob_sticky: got %b, required 1", err_oob);
        end
    endtask

    task automatic test_reset_mid_op();
        video_enable = 1'b1;
        goto_state(2'd3);
        // Read first so it issues in state 2 while three writes remain queued.
        for (int i = 0; i < 4; i++) begin
            cpu_req_valid = 1'b1;
            cpu_req_we    = (i != 0);
            cpu_req_addr  = (i == 0) ? 15'h0005 : 15'h0030 + 15'(i);
            cpu_req_wdata = 16'hC000 + 16'(i);
            @(negedge clk);
            n_checks++;
            if (cpu_req_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL midrst_fill: entry %0d got ready=%b, required 1", i, cpu_req_ready);
            end
            tick();
        end
        cpu_req_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (cpu_rsp_valid !== 1'b0 || mem_we !== 1'b0 || cpu_req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_during: got rv=%b we=%b ready=%b, required 0/0/0",
                     cpu_rsp_valid, mem_we, cpu_req_ready);
        end
        tick();
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (cpu_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_ready: got %b, required 1", cpu_req_ready);
        end
        n_checks++;
        if (err_oob !== 1'b0 || cpu_rsp_valid !== 1'b0 || pg_data !== 16'h0) begin
            n_fail++;
            $display("FAIL midrst_clear: got err=%b rv=%b pg=%h, required 0/0/0000",
                     err_oob, cpu_rsp_valid, pg_data);
        end
        repeat (10) tick();
        send(1'b1, 15'h0102, 16'h7777);
        wait_drain();
        n_checks++;
        if (exp_wr_q.size() != 0 || exp_rsp_q.size() != 0) begin
            n_fail++;
            $display("FAIL midrst_flush: got %0d/%0d pending, required 0/0",
                     exp_wr_q.size(), exp_rsp_q.size());
        end
    endtask

    initial begin
        vram[15'h0005]   = 16'h0041;
        vram[15'h2104]   = 16'h3C66;
        shadow[15'h0005] = 16'h0041;
        shadow[15'h2104] = 16'h3C66;
        test_reset();
        test_video_fetch();
        test_write_slotting();
        test_backpressure();
        test_read();
        test_out_of_range();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000 time units, required completion");
        $fatal(1, "timeout");
    end

endmodule
